entity_pool: RTL and testbench

- Parametrised successor to the fixed turret/button/bullet RAM slots. Holds up to DEPTH game entities of DATA_W bits each.
- Provides:
  - a free-slot allocator with a spawn handshake,
  - a per-frame update sweep that hands each live entity to the datapath, which keeps, rewrites or kills it,
  - an independent 1-cycle render read port for the VGA controller.
- One instance replaces each hand-wired object RAM.

---
 rtl/entity_pool.sv | 180 ++++++++++++++++++
 tb/tb_entity_pool.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/entity_pool.sv
// entity_pool: entity slot RAM with free-slot allocator, per-frame update sweep and render read port.
// Define ENTITY_POOL_STATS_EN to add the peak_count and drop_count statistics outputs.
module entity_pool #(
    parameter int DEPTH  = 128,
    parameter int DATA_W = 18,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spawn_valid,
    input  logic [DATA_W-1:0] spawn_data,
    output logic              spawn_ready,
    output logic [ADDR_W-1:0] spawn_addr,
    input  logic              frame_tick,
    output logic              sweep_valid,
    output logic [ADDR_W-1:0] sweep_addr,
    output logic [DATA_W-1:0] sweep_data,
    input  logic              sweep_resp,
    input  logic              sweep_kill,
    input  logic [DATA_W-1:0] sweep_wdata,
    output logic              sweep_done,
    output logic              sweep_overrun,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_live,
    output logic [ADDR_W:0]   live_count
`ifdef ENTITY_POOL_STATS_EN
    ,
    output logic [ADDR_W:0]   peak_count,
    output logic [15:0]       drop_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_FETCH,
        S_WAIT,
        S_FINISH
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_live;
    logic [ADDR_W:0]   r_count;
    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_idx;
    logic              r_sv;
    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] r_sdata;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_live;
    logic [ADDR_W-1:0] w_free;
    logic              w_spawn;
    logic              w_resp;
    logic              w_kill;
    logic              w_wr;
    logic              w_last;

    // Lowest-index dead slot wins.
    always_comb begin
        w_free = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_live[i]) w_free = ADDR_W'(i);
        end
    end

    assign spawn_ready = !reset && (r_state == S_IDLE) &&
                         (r_count < FULL) && !frame_tick;
    assign w_spawn     = spawn_valid && spawn_ready;
    assign w_resp      = !reset && (r_state == S_WAIT) && sweep_resp;
    assign w_kill      = w_resp && sweep_kill;
    assign w_wr        = w_resp && !sweep_kill;
    assign w_last      = (r_idx == LAST);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (frame_tick) w_next = S_SCAN;
            S_SCAN: begin
                if (r_live[r_idx]) w_next = S_FETCH;
                else if (w_last)   w_next = S_FINISH;
            end
            S_FETCH:  w_next = S_WAIT;
            S_WAIT:   if (sweep_resp) w_next = w_last ? S_FINISH : S_SCAN;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_sv    <= 1'b0;
            r_sdata <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE:  if (frame_tick) r_idx <= '0;
                S_SCAN:  if (!r_live[r_idx] && !w_last) r_idx <= r_idx + 1'b1;
                S_FETCH: begin
                    r_sv    <= 1'b1;
                    r_sdata <= r_q;
                end
                S_WAIT: begin
                    if (sweep_resp) begin
                        r_sv <= 1'b0;
                        if (!w_last) r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Port A: spawn and sweep never overlap, so one write path suffices.
    always_ff @(posedge clk) begin
        if (w_spawn)   r_mem[w_free] <= spawn_data;
        else if (w_wr) r_mem[r_idx]  <= sweep_wdata;
        r_q <= r_mem[r_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_live  <= '0;
            r_count <= '0;
        end else if (w_spawn) begin
            r_live[w_free] <= 1'b1;
            r_count        <= r_count + 1'b1;
        end else if (w_kill) begin
            r_live[r_idx] <= 1'b0;
            r_count       <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
            r_rd_live <= 1'b0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
            r_rd_live <= r_live[rd_addr];
        end
    end

`ifdef ENTITY_POOL_STATS_EN
    logic [ADDR_W:0] r_peak;
    logic [15:0]     r_drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_peak <= '0;
            r_drop <= '0;
        end else begin
            if (r_count > r_peak) r_peak <= r_count;
            if (spawn_valid && !spawn_ready && (r_count == FULL) &&
                (r_drop != 16'hFFFF))
                r_drop <= r_drop + 16'd1;
        end
    end

    assign peak_count = r_peak;
    assign drop_count = r_drop;
`endif

    assign spawn_addr    = reset ? '0 : w_free;
    assign sweep_valid   = r_sv;
    assign sweep_addr    = r_idx;
    assign sweep_data    = r_sdata;
    assign sweep_done    = (r_state == S_FINISH);
    assign sweep_overrun = !reset && frame_tick && (r_state != S_IDLE);
    assign rd_data       = r_rd_data;
    assign rd_live       = r_rd_live;
    assign live_count    = r_count;

endmodule

// File: tb/tb_entity_pool.sv
// tb_entity_pool: scoreboard bench for entity_pool at DEPTH=8.
// Expectations are queued by stimulus and popped by a negedge monitor.
module tb_entity_pool;

    localparam int DEPTH = 8;
    localparam int DW    = 18;
    localparam int AW    = 3;

    typedef struct {
        int          dly;
        bit          kill;
        logic [DW-1:0] wdata;
    } rsp_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } sw_t;

    typedef struct {
        logic [DW-1:0] d;
        bit            chkd;
        logic          live;
    } rd_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          spawn_valid = 1'b0;
    logic [DW-1:0] spawn_data = '0;
    logic          spawn_ready;
    logic [AW-1:0] spawn_addr;
    logic          frame_tick = 1'b0;
    logic          sweep_valid;
    logic [AW-1:0] sweep_addr;
    logic [DW-1:0] sweep_data;
    logic          sweep_resp;
    logic          sweep_kill;
    logic [DW-1:0] sweep_wdata;
    logic          sweep_done;
    logic          sweep_overrun;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_live;
    logic [AW:0]   live_count;
`ifdef ENTITY_POOL_STATS_EN
    logic [AW:0]   peak_count;
    logic [15:0]   drop_count;
`endif
    logic          rd_req = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] exp_spawn [$];
    sw_t           exp_sweep [$];
    logic [AW-1:0] exp_done  [$];
    rd_t           exp_rd    [$];
    rsp_t          rsp_q     [$];

    entity_pool #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .spawn_valid  (spawn_valid),
        .spawn_data   (spawn_data),
        .spawn_ready  (spawn_ready),
        .spawn_addr   (spawn_addr),
        .frame_tick   (frame_tick),
        .sweep_valid  (sweep_valid),
        .sweep_addr   (sweep_addr),
        .sweep_data   (sweep_data),
        .sweep_resp   (sweep_resp),
        .sweep_kill   (sweep_kill),
        .sweep_wdata  (sweep_wdata),
        .sweep_done   (sweep_done),
        .sweep_overrun(sweep_overrun),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_live      (rd_live),
        .live_count   (live_count)
`ifdef ENTITY_POOL_STATS_EN
        ,
        .peak_count   (peak_count),
        .drop_count   (drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_evt(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event not expected or never seen", nm);
    endtask

    // Monitor: pops expectations whenever the DUT presents a response.
    logic prev_sv = 1'b0;
    bit   rd_pend = 1'b0;
    always @(negedge clk) begin : mon
        sw_t s;
        rd_t r;
        if (!reset) begin
            if (spawn_valid && spawn_ready) begin
                if (exp_spawn.size() == 0) fail_evt("spawn_unexpected");
                else chk("spawn_addr", 32'(spawn_addr), 32'(exp_spawn.pop_front()));
            end
            if (sweep_valid && !prev_sv) begin
                if (exp_sweep.size() == 0) fail_evt("sweep_unexpected");
                else begin
                    s = exp_sweep.pop_front();
                    chk("sweep_addr", 32'(sweep_addr), 32'(s.a));
                    chk("sweep_data", 32'(sweep_data), 32'(s.d));
                end
            end
            if (sweep_done) begin
                if (exp_done.size() == 0) fail_evt("done_unexpected");
                else chk("done_idx", 32'(sweep_addr), 32'(exp_done.pop_front()));
            end
            if (rd_pend) begin
                r = exp_rd.pop_front();
                chk("rd_live", 32'(rd_live), 32'(r.live));
                if (r.chkd) chk("rd_data", 32'(rd_data), 32'(r.d));
            end
            rd_pend = rd_req;
        end else begin
            rd_pend = 1'b0;
        end
        prev_sv = sweep_valid;
    end

    // Datapath model: answers each presentation after its queued delay.
    initial begin : responder
        int   wcnt;
        rsp_t r;
        wcnt = 0;
        sweep_resp = 1'b0;
        sweep_kill = 1'b0;
        sweep_wdata = '0;
        forever begin
            @(posedge clk);
            #1;
            sweep_resp = 1'b0;
            sweep_kill = 1'b0;
            if (!sweep_valid || reset) begin
                wcnt = 0;
            end else if (rsp_q.size() == 0) begin
                sweep_resp  = 1'b1;
                sweep_wdata = sweep_data;
            end else if (wcnt >= rsp_q[0].dly) begin
                r = rsp_q.pop_front();
                sweep_resp  = 1'b1;
                sweep_kill  = r.kill;
                sweep_wdata = r.wdata;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic spawn(input logic [DW-1:0] d, input logic [AW-1:0] a);
        bit acc;
        acc = 1'b0;
        exp_spawn.push_back(a);
        spawn_valid = 1'b1;
        spawn_data  = d;
        for (int n = 0; n < 40 && !acc; n++) begin
            @(negedge clk);
            acc = spawn_ready;
            step();
        end
        spawn_valid = 1'b0;
        if (!acc) fail_evt("spawn_timeout");
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit chkd, input logic live);
        rd_t r;
        r.d = d;
        r.chkd = chkd;
        r.live = live;
        exp_rd.push_back(r);
        rd_addr = a;
        rd_req  = 1'b1;
        step();
        rd_req  = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            seen = sweep_done;
            step();
        end
        if (!seen) fail_evt("done_timeout");
    endtask

    function automatic rsp_t mk_rsp(int dly, bit kill, logic [DW-1:0] w);
        rsp_t r;
        r.dly = dly;
        r.kill = kill;
        r.wdata = w;
        return r;
    endfunction

    function automatic sw_t mk_sw(logic [AW-1:0] a, logic [DW-1:0] d);
        sw_t s;
        s.a = a;
        s.d = d;
        return s;
    endfunction

    initial begin : stim
        bit acc;
        bit prev_done;
        bit seen;
        int cyc;

        // Reset state, sampled while reset is still asserted.
        step();
        step();
        @(negedge clk);
        chk("rst_live_count", 32'(live_count), 0);
        chk("rst_spawn_ready", 32'(spawn_ready), 0);
        chk("rst_sweep_valid", 32'(sweep_valid), 0);
        chk("rst_sweep_done", 32'(sweep_done), 0);
        chk("rst_rd_live", 32'(rd_live), 0);
        chk("rst_spawn_addr", 32'(spawn_addr), 0);
        step();
        reset = 1'b0;

        // Three spawns and a render read.
        spawn(18'h00011, 3'd0);
        spawn(18'h00022, 3'd1);
        spawn(18'h00033, 3'd2);
        @(negedge clk);
        chk("count_3", 32'(live_count), 3);
        step();
        rd(3'd1, 18'h00022, 1'b1, 1'b1);
        rd(3'd5, 18'h0, 1'b0, 1'b0);

        // Sweep: keep+rewrite 0, kill 1, keep 2 after 3-cycle delay.
        rsp_q.push_back(mk_rsp(0, 1'b0, 18'h3FFFF));
        rsp_q.push_back(mk_rsp(0, 1'b1, 18'h0));
        rsp_q.push_back(mk_rsp(3, 1'b0, 18'h00333));
        exp_sweep.push_back(mk_sw(3'd0, 18'h00011));
        exp_sweep.push_back(mk_sw(3'd1, 18'h00022));
        exp_sweep.push_back(mk_sw(3'd2, 18'h00033));
        exp_done.push_back(3'd7);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        wait_done();
        @(negedge clk);
        chk("count_after_sweep", 32'(live_count), 2);
        step();
        rd(3'd0, 18'h3FFFF, 1'b1, 1'b1);
        rd(3'd1, 18'h0, 1'b0, 1'b0);
        rd(3'd2, 18'h00333, 1'b1, 1'b1);
        spawn(18'h00044, 3'd1);

        // Spawn and frame_tick together: spawn waits for the sweep.
        rsp_q.push_back(mk_rsp(0, 1'b0, 18'h3FFFF));
        rsp_q.push_back(mk_rsp(0, 1'b0, 18'h00044));
        rsp_q.push_back(mk_rsp(0, 1'b0, 18'h00333));
        exp_sweep.push_back(mk_sw(3'd0, 18'h3FFFF));
        exp_sweep.push_back(mk_sw(3'd1, 18'h00044));
        exp_sweep.push_back(mk_sw(3'd2, 18'h00333));
        exp_done.push_back(3'd7);
        exp_spawn.push_back(3'd3);
        spawn_valid = 1'b1;
        spawn_data  = 18'h00055;
        frame_tick  = 1'b1;
        @(negedge clk);
        chk("ready_with_tick", 32'(spawn_ready), 0);
        step();
        frame_tick = 1'b0;
        acc = 1'b0;
        prev_done = 1'b0;
        for (int n = 0; n < 80 && !acc; n++) begin
            @(negedge clk);
            if (spawn_ready) begin
                acc = 1'b1;
                chk("spawn_after_done", 32'(prev_done), 1);
            end
            prev_done = sweep_done;
            step();
        end
        spawn_valid = 1'b0;
        if (!acc) fail_evt("held_spawn_timeout");
        @(negedge clk);
        chk("count_4", 32'(live_count), 4);
        step();

        // Empty pool sweep with an overrun tick mid-sweep.
        do_reset();
        exp_done.push_back(3'd7);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        seen = 1'b0;
        cyc = 0;
        for (int n = 1; n <= 30 && !seen; n++) begin
            if (n == 4) frame_tick = 1'b1;
            @(negedge clk);
            if (frame_tick) chk("overrun", 32'(sweep_overrun), 1);
            seen = sweep_done;
            cyc = n;
            step();
            frame_tick = 1'b0;
        end
        if (!seen) fail_evt("empty_done_timeout");
        else chk("empty_sweep_cycles", 32'(cyc), 9);
        repeat (15) step();

        // Fill the pool, then hold a spawn against it.
        for (int i = 0; i < DEPTH; i++) begin
            spawn(18'(i * 'h101), AW'(i));
        end
        @(negedge clk);
        chk("full_ready", 32'(spawn_ready), 0);
        chk("full_count", 32'(live_count), 8);
        step();
        spawn_valid = 1'b1;
        spawn_data  = 18'h00777;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("full_held_ready", 32'(spawn_ready), 0);
            step();
        end
        spawn_valid = 1'b0;
`ifdef ENTITY_POOL_STATS_EN
        @(negedge clk);
        chk("drop_count", 32'(drop_count), 5);
        chk("peak_count", 32'(peak_count), 8);
        step();
`endif

        // Reset while the sweep waits on slot 0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            spawn(18'(18'h00100 + i), AW'(i));
        end
        rsp_q.push_back(mk_rsp(100, 1'b0, 18'h0));
        exp_sweep.push_back(mk_sw(3'd0, 18'h00100));
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = sweep_valid;
            step();
        end
        if (!seen) fail_evt("wait_state_timeout");
        reset = 1'b1;
        step();
        reset = 1'b0;
        rsp_q.delete();
        @(negedge clk);
        chk("rst_wait_count", 32'(live_count), 0);
        chk("rst_wait_valid", 32'(sweep_valid), 0);
        chk("rst_wait_ready", 32'(spawn_ready), 1);
        chk("rst_wait_done", 32'(sweep_done), 0);
        step();
        for (int i = 0; i < DEPTH; i++) begin
            rd(AW'(i), 18'h0, 1'b0, 1'b0);
        end
        repeat (12) step();

        chk("spawn_q_left", 32'(exp_spawn.size()), 0);
        chk("sweep_q_left", 32'(exp_sweep.size()), 0);
        chk("done_q_left", 32'(exp_done.size()), 0);
        chk("rd_q_left", 32'(exp_rd.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
